// File: rtl/im_sync_fetch_pkg.sv
// Shared constants and helpers for the synchronous instruction-fetch memory.
// Entry layout in the response buffer is {pc, instr, exc}, MSB first.
package im_sync_fetch_pkg;

  localparam logic [31:0] IM_BASE_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] IM_NOP          = 32'h0000_0000;
  localparam int          IM_PC_W         = 32;
  localparam int          IM_EXC_W        = 1;

  function automatic int im_entry_w(input int data_w);
    return IM_PC_W + data_w + IM_EXC_W;
  endfunction

  // idx is the already-shifted word offset from the base; a pc below the base
  // wraps to a huge idx, but the explicit compare keeps the intent readable.
  function automatic logic im_addr_exc(input logic [31:0] pc,
                                       input logic [31:0] base,
                                       input logic [31:0] idx,
                                       input logic [31:0] depth);
    return (pc[1:0] != 2'b00) || (pc < base) || (idx >= depth);
  endfunction

endpackage

// File: rtl/im_sync_fetch_fifo.sv
// Generic synchronous FIFO with clear; reads are first-word-fall-through, zero when empty.
// Push while full is honoured only together with a pop; reset beats clear, clear beats push/pop.
module fetch_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop & ~empty;
  assign do_push  = push & (~full | do_pop);
  assign pop_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage carries no reset; stale words are masked by empty.
  always_ff @(posedge clk) begin
    if (!reset && !clear && do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/im_sync_fetch.sv
// Instruction memory with registered read into a BUF_DEPTH response buffer: 1-cycle latency, 1/cycle.
// req_ready drops when the buffer is full and not draining, during flush, and during reset.
module im_sync_fetch
  import im_sync_fetch_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR   = IM_BASE_DEFAULT,
  parameter int          DEPTH_WORDS = 4096,
  parameter int          DATA_W      = 32,
  parameter int          BUF_DEPTH   = 2,
  // Program image, word 0 in the least significant DATA_W bits; not touched by reset.
  parameter logic [DEPTH_WORDS*DATA_W-1:0] INIT_IMAGE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_pc,
  input  logic              flush,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [31:0]       resp_pc,
  output logic [DATA_W-1:0] resp_instr,
  output logic              resp_exc
);

  localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam int EW = im_entry_w(DATA_W);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  logic [31:0]       idx;
  logic              exc;
  logic [DATA_W-1:0] rom_word;
  logic [DATA_W-1:0] instr;
  logic [EW-1:0]     push_data;
  logic [EW-1:0]     head;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [CW-1:0]     count;

  assign idx      = (req_pc - BASE_ADDR) >> 2;
  assign exc      = im_addr_exc(req_pc, BASE_ADDR, idx, 32'(DEPTH_WORDS));
  assign rom_word = INIT_IMAGE[idx[AW-1:0]*DATA_W +: DATA_W];
  assign instr    = exc ? DATA_W'(IM_NOP) : rom_word;

  assign push_data = {req_pc, instr, exc};

  // A full buffer can still accept when the head leaves in the same cycle.
  assign req_ready  = ~reset & ~flush & (~full | (resp_valid & resp_ready));
  assign push       = req_valid & req_ready;
  assign pop        = resp_ready & ~empty & ~flush;
  assign resp_valid = (count != '0);

  fetch_fifo #(
    .WIDTH (EW),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .clear     (flush),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .pop_data  (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign {resp_pc, resp_instr, resp_exc} = head;

endmodule
